// File: rtl/vx_writeback_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_writeback_arb
// Purpose  : Merges per-unit commit streams into one registered writeback
//            stream, round-robin per packet, never interleaving sop..eop.
// Revision : 1.0
// ============================================================================
module vx_writeback_arb #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_W       = 1,
    parameter int UUID_W      = 44
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_INPUTS-1:0]             cm_valid,
    output logic [NUM_INPUTS-1:0]             cm_ready,
    input  logic [NUM_INPUTS*UUID_W-1:0]      cm_uuid,
    input  logic [NUM_INPUTS*WIS_W-1:0]       cm_wis,
    input  logic [NUM_INPUTS*NUM_THREADS-1:0] cm_tmask,
    input  logic [NUM_INPUTS*XLEN-1:0]        cm_pc,
    input  logic [NUM_INPUTS-1:0]             cm_wb,
    input  logic [NUM_INPUTS*NR_BITS-1:0]     cm_rd,
    input  logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] cm_data,
    input  logic [NUM_INPUTS-1:0]             cm_sop,
    input  logic [NUM_INPUTS-1:0]             cm_eop,
    output logic                              wb_valid,
    output logic [UUID_W-1:0]                 wb_uuid,
    output logic [WIS_W-1:0]                  wb_wis,
    output logic [NUM_THREADS-1:0]            wb_tmask,
    output logic [XLEN-1:0]                   wb_pc,
    output logic [NR_BITS-1:0]                wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]       wb_data,
    output logic                              wb_sop,
    output logic                              wb_eop,
    output logic                              retire_valid,
    output logic [WIS_W-1:0]                  retire_wis
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;

    logic             w_any;
    logic [IDX_W-1:0] w_gidx;

    // Descending scans leave the lowest hit; the second scan overrides with
    // the lowest valid at/after the pointer, giving a cyclic search.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        if (r_state == ST_LOCKED) begin
            w_any  = cm_valid[r_owner];
            w_gidx = r_owner;
        end else begin
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                if (cm_valid[i]) begin
                    w_any  = 1'b1;
                    w_gidx = IDX_W'(i);
                end
            end
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                if (cm_valid[i] && (IDX_W'(i) >= r_rr_ptr)) begin
                    w_any  = 1'b1;
                    w_gidx = IDX_W'(i);
                end
            end
        end
    end

    assign cm_ready = w_any ? (NUM_INPUTS'(1) << w_gidx) : '0;

    logic                        w_sop;
    logic                        w_eop;
    logic                        w_wb;
    logic [NUM_THREADS-1:0]      w_tmask;
    logic [WIS_W-1:0]            w_wis;
    logic [IDX_W-1:0]            w_next_ptr;

    assign w_sop      = cm_sop[w_gidx];
    assign w_eop      = cm_eop[w_gidx];
    assign w_wb       = cm_wb[w_gidx];
    assign w_tmask    = cm_tmask[w_gidx*NUM_THREADS +: NUM_THREADS];
    assign w_wis      = cm_wis[w_gidx*WIS_W +: WIS_W];
    assign w_next_ptr = (w_gidx == IDX_W'(NUM_INPUTS - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_UNLOCKED;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            wb_valid     <= 1'b0;
            retire_valid <= 1'b0;
        end else begin
            wb_valid     <= w_any && w_wb && (|w_tmask);
            retire_valid <= w_any && w_eop;
            if (w_any) begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_sop && !w_eop) begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_gidx;
                        end else if (w_eop) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_eop) begin
                            r_state  <= ST_UNLOCKED;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                    default: r_state <= ST_UNLOCKED;
                endcase
            end
        end
    end

    // Payload registers carry no reset; wb_valid/retire_valid qualify them.
    always_ff @(posedge clk) begin
        wb_uuid    <= cm_uuid[w_gidx*UUID_W +: UUID_W];
        wb_wis     <= w_wis;
        wb_tmask   <= w_tmask;
        wb_pc      <= cm_pc[w_gidx*XLEN +: XLEN];
        wb_rd      <= cm_rd[w_gidx*NR_BITS +: NR_BITS];
        wb_data    <= cm_data[w_gidx*NUM_THREADS*XLEN +: NUM_THREADS*XLEN];
        wb_sop     <= w_sop;
        wb_eop     <= w_eop;
        retire_wis <= w_wis;
    end

`ifndef SYNTHESIS
    a_sop_when_unlocked: assert property (@(posedge clk) disable iff (reset)
        (w_any && r_state == ST_UNLOCKED) |-> w_sop);
    a_no_sop_when_locked: assert property (@(posedge clk) disable iff (reset)
        (w_any && r_state == ST_LOCKED) |-> !w_sop);
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_writeback_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_writeback_arb
// Purpose  : Directed self-checking bench for the writeback arbiter.
// Revision : 1.0
// ============================================================================
module tb_vx_writeback_arb;

    localparam int N = 4;
    localparam int T = 4;
    localparam int X = 32;
    localparam int R = 6;
    localparam int W = 1;
    localparam int U = 44;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]     cm_valid, cm_ready, cm_wb, cm_sop, cm_eop;
    logic [N*U-1:0]   cm_uuid;
    logic [N*W-1:0]   cm_wis;
    logic [N*T-1:0]   cm_tmask;
    logic [N*X-1:0]   cm_pc;
    logic [N*R-1:0]   cm_rd;
    logic [N*T*X-1:0] cm_data;
    logic             wb_valid, wb_sop, wb_eop, retire_valid;
    logic [U-1:0]     wb_uuid;
    logic [W-1:0]     wb_wis, retire_wis;
    logic [T-1:0]     wb_tmask;
    logic [X-1:0]     wb_pc;
    logic [R-1:0]     wb_rd;
    logic [T*X-1:0]   wb_data;

    logic           s_v   [N];
    logic           s_sop [N];
    logic           s_eop [N];
    logic           s_wb  [N];
    logic [T-1:0]   s_tm  [N];
    logic [R-1:0]   s_rd  [N];
    logic [W-1:0]   s_wis [N];
    logic [X-1:0]   s_pc  [N];
    logic [U-1:0]   s_uuid[N];
    logic [T*X-1:0] s_data[N];

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign cm_valid[k]           = s_v[k];
        assign cm_sop[k]             = s_sop[k];
        assign cm_eop[k]             = s_eop[k];
        assign cm_wb[k]              = s_wb[k];
        assign cm_tmask[k*T +: T]    = s_tm[k];
        assign cm_rd[k*R +: R]       = s_rd[k];
        assign cm_wis[k*W +: W]      = s_wis[k];
        assign cm_pc[k*X +: X]       = s_pc[k];
        assign cm_uuid[k*U +: U]     = s_uuid[k];
        assign cm_data[k*T*X +: T*X] = s_data[k];
    end

    vx_writeback_arb #(
        .NUM_INPUTS(N), .NUM_THREADS(T), .XLEN(X), .NR_BITS(R), .WIS_W(W), .UUID_W(U)
    ) dut (
        .clk(clk), .reset(reset),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_uuid(cm_uuid), .cm_wis(cm_wis),
        .cm_tmask(cm_tmask), .cm_pc(cm_pc), .cm_wb(cm_wb), .cm_rd(cm_rd), .cm_data(cm_data),
        .cm_sop(cm_sop), .cm_eop(cm_eop),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wis(wb_wis), .wb_tmask(wb_tmask),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
        .retire_valid(retire_valid), .retire_wis(retire_wis)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [T*X-1:0] mkdata(input int k, input int rd);
        logic [T*X-1:0] d;
        for (int l = 0; l < T; l++)
            d[l*X +: X] = (32'(k) << 24) | (32'(rd) << 16) | (32'(l) << 8) | 32'h5A;
        return d;
    endfunction

    task automatic set_src(input int k, input bit v, input bit sop, input bit eop, input bit wb,
                           input logic [T-1:0] tm, input int rd, input logic [W-1:0] wis);
        s_v[k]    = v;
        s_sop[k]  = sop;
        s_eop[k]  = eop;
        s_wb[k]   = wb;
        s_tm[k]   = tm;
        s_rd[k]   = R'(rd);
        s_wis[k]  = wis;
        s_pc[k]   = 32'h1000 + 32'(k * 4);
        s_uuid[k] = U'(100 + k + rd);
        s_data[k] = mkdata(k, rd);
    endtask

    task automatic idle(input int k);
        s_v[k] = 1'b0;
    endtask

    // Inputs are set at a negedge; check the combinational grant, then move
    // to the next negedge where the registered result of that grant is visible.
    task automatic cyc(input string tag, input logic [N-1:0] er);
        #1;
        check(tag, 128'(cm_ready), 128'(er));
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < N; k++) set_src(k, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wbv", 128'(wb_valid), 128'(0));
        check("rst_ret", 128'(retire_valid), 128'(0));
        reset = 1'b0;

        // 1: idle
        repeat (10) begin
            cyc("t1_ready", 4'b0000);
            check("t1_wbv", 128'(wb_valid), 128'(0));
            check("t1_ret", 128'(retire_valid), 128'(0));
        end

        // 2: four single-beat packets together, then rr wrap
        for (int k = 0; k < N; k++) set_src(k, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, k + 1, '0);
        for (int k = 0; k < N; k++) begin
            cyc("t2_ready", 4'(1 << k));
            check("t2_wbv", 128'(wb_valid), 128'(1));
            check("t2_rd", 128'(wb_rd), 128'(k + 1));
            check("t2_ret", 128'(retire_valid), 128'(1));
            check("t2_data", 128'(wb_data), 128'(mkdata(k, k + 1)));
            check("t2_pc", 128'(wb_pc), 128'(32'h1000 + k * 4));
            check("t2_uuid", 128'(wb_uuid), 128'(101 + 2 * k));
            idle(k);
        end
        set_src(2, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 3, '0);
        cyc("t2_wrap_ready", 4'b0100);
        check("t2_wrap_rd", 128'(wb_rd), 128'(3));
        idle(2);

        // 3: src1 3-beat packet against src0 singles (rr now 3)
        set_src(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 10, '0);
        set_src(1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, 5, '0);
        cyc("t3_first_ready", 4'b0001);
        check("t3_first_rd", 128'(wb_rd), 128'(10));
        set_src(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 11, '0);
        cyc("t3_b0_ready", 4'b0010);
        check("t3_b0_rd", 128'(wb_rd), 128'(5));
        check("t3_b0_tm", 128'(wb_tmask), 128'(4'b0011));
        check("t3_b0_sop", 128'({wb_sop, wb_eop}), 128'(2'b10));
        check("t3_b0_ret", 128'(retire_valid), 128'(0));
        set_src(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 5, '0);
        cyc("t3_b1_ready", 4'b0010);
        check("t3_b1_tm", 128'(wb_tmask), 128'(4'b1100));
        check("t3_b1_sop", 128'({wb_sop, wb_eop}), 128'(2'b00));
        set_src(1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 5, '0);
        cyc("t3_b2_ready", 4'b0010);
        check("t3_b2_tm", 128'(wb_tmask), 128'(4'hF));
        check("t3_b2_eop", 128'({wb_sop, wb_eop}), 128'(2'b01));
        check("t3_b2_ret", 128'(retire_valid), 128'(1));
        idle(1);
        cyc("t3_next_ready", 4'b0001);
        check("t3_next_rd", 128'(wb_rd), 128'(11));
        idle(0);

        // 4: retire without write (rr now 1)
        set_src(2, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 9, 1'b1);
        cyc("t4_ready", 4'b0100);
        check("t4_wbv", 128'(wb_valid), 128'(0));
        check("t4_ret", 128'(retire_valid), 128'(1));
        check("t4_wis", 128'(retire_wis), 128'(1));
        idle(2);

        // 5: reset while src3 holds the lock (rr now 3)
        set_src(3, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 12, '0);
        cyc("t5_sop_ready", 4'b1000);
        check("t5_sop", 128'({wb_valid, wb_sop}), 128'(2'b11));
        set_src(3, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 12, '0);
        set_src(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 7, '0);
        cyc("t5_locked_ready", 4'b1000);
        check("t5_locked_rd", 128'(wb_rd), 128'(12));
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        check("t5_rst_wbv", 128'(wb_valid), 128'(0));
        check("t5_rst_ret", 128'(retire_valid), 128'(0));
        reset = 1'b0;
        cyc("t5_after_ready", 4'b0001);
        check("t5_after_wbv", 128'(wb_valid), 128'(1));
        check("t5_after_rd", 128'(wb_rd), 128'(7));
        idle(0);

        // 6: owner idle while locked (rr now 1)
        set_src(1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 8, '0);
        cyc("t6_sop_ready", 4'b0010);
        check("t6_sop_rd", 128'(wb_rd), 128'(8));
        idle(1);
        set_src(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 20, '0);
        set_src(2, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 21, '0);
        set_src(3, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 22, '0);
        repeat (5) begin
            cyc("t6_hold_ready", 4'b0000);
            check("t6_hold_wbv", 128'(wb_valid), 128'(0));
        end
        set_src(1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 8, '0);
        cyc("t6_eop_ready", 4'b0010);
        check("t6_eop_wbv", 128'(wb_valid), 128'(1));
        check("t6_eop_ret", 128'(retire_valid), 128'(1));
        idle(1);
        cyc("t6_release_ready", 4'b0100);
        check("t6_release_rd", 128'(wb_rd), 128'(21));
        for (int k = 0; k < N; k++) idle(k);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
